// File: rtl/isqrt_seq.sv
// isqrt_seq: iterative y = floor(sqrt(x)) engine, 32-bit operand to 16-bit root, with a
// DEPTH-entry request queue. Define ISQRT_SEQ_RADIX4_EN for two root bits per cycle.
module isqrt_seq #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        x_vld,
   input  logic [31:0] x,
   output logic        y_vld,
   output logic [15:0] y,
   output logic        busy,
   output logic        ovf
);
`ifdef ISQRT_SEQ_RADIX4_EN
   localparam int unsigned N = 8;
`else
   localparam int unsigned N = 16;
`endif
   localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned SLOTS = 1 << PW;

   typedef enum logic {IDLE, CALC} state_t;
   state_t state, state_nx;

   logic [3:0]    cnt;
   logic [31:0]   op, op_nx;
   logic [17:0]   rem, rem_nx;
   logic [15:0]   root, root_nx;
   logic [31:0]   fifo_mem [SLOTS];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [3:0]    count, count_nx;
   logic          done, load_x, pop, push, drop, busy_nx;
   logic [31:0]   load_val;

   // Returns {rem, root} after consuming two operand bits.
   function automatic logic [33:0] sqrt_step(input logic [17:0] r_in,
                                             input logic [15:0] q_in,
                                             input logic [1:0]  bits);
      logic [17:0] r_sh;
      logic [17:0] t;
      logic [17:0] diff;
      r_sh = {r_in[15:0], bits};
      t    = {q_in, 2'b01};
      diff = r_sh - t;
      if (r_sh >= t) return {diff, q_in[14:0], 1'b1};
      return {r_sh, q_in[14:0], 1'b0};
   endfunction

   function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

`ifdef ISQRT_SEQ_RADIX4_EN
   logic [33:0] step_a, step_b;
   always_comb begin
      step_a  = sqrt_step(rem, root, op[31:30]);
      step_b  = sqrt_step(step_a[33:16], step_a[15:0], op[29:28]);
      op_nx   = {op[27:0], 4'b0000};
      rem_nx  = step_b[33:16];
      root_nx = step_b[15:0];
   end
`else
   logic [33:0] step_a;
   always_comb begin
      step_a  = sqrt_step(rem, root, op[31:30]);
      op_nx   = {op[29:0], 2'b00};
      rem_nx  = step_a[33:16];
      root_nx = step_a[15:0];
   end
`endif

   always_comb begin
      done     = (state == CALC) && (cnt == '0);
      pop      = done && (count != '0);
      load_x   = x_vld && (count == '0) && ((state == IDLE) || done);
      // A pop on the same edge frees a slot, so a full queue can still accept.
      push     = x_vld && !load_x && ((count != 4'(DEPTH)) || pop);
      drop     = x_vld && !load_x && (count == 4'(DEPTH)) && !pop;
      load_val = pop ? fifo_mem[rd_ptr] : x;
      count_nx = count + {3'b000, push} - {3'b000, pop};
      state_nx = state;
      if (pop || load_x)
         state_nx = CALC;
      else if (done)
         state_nx = IDLE;
      busy_nx  = (state_nx == CALC) || (count_nx != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         op     <= '0;
         rem    <= '0;
         root   <= '0;
         y      <= '0;
         y_vld  <= 1'b0;
         busy   <= 1'b0;
         ovf    <= 1'b0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         y_vld <= done;
         if (done)
            y <= root_nx;
         if (pop || load_x) begin
            op   <= load_val;
            rem  <= '0;
            root <= '0;
            cnt  <= 4'(N - 1);
         end else if (state == CALC && !done) begin
            op   <= op_nx;
            rem  <= rem_nx;
            root <= root_nx;
            cnt  <= cnt - 4'd1;
         end
         if (push)
            wr_ptr <= adv(wr_ptr);
         if (pop)
            rd_ptr <= adv(rd_ptr);
         count <= count_nx;
         busy  <= busy_nx;
         if (drop)
            ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= x;
   end
endmodule
